// File: rtl/prbs31_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1), used by both the generator and
// the checker: LFSR width, feedback taps and the checker state encoding.
package prbs31_pkg;

   localparam int LFSR_W = 31;
   localparam int TAP_A  = 30;
   localparam int TAP_B  = 27;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/prbs31_step.sv
// One PRBS31 step: the predicted next bit from the current LFSR contents and
// the shifted register after a chosen bit is inserted. Purely combinational.
module prbs31_step
   import prbs31_pkg::*;
(
   input  logic [LFSR_W-1:0] lfsr_i,
   input  logic              bit_i,
   output logic              pred_o,
   output logic [LFSR_W-1:0] lfsr_next_o
);

   assign pred_o      = lfsr_i[TAP_A] ^ lfsr_i[TAP_B];
   assign lfsr_next_o = {lfsr_i[LFSR_W-2:0], bit_i};

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-synchronising search/verify, lock detection,
// per-bit error pulses, saturating error counter and windowed loss of lock.
// Optional macro PRBS31_CHK_INV_EN adds the inv_in port, which inverts the
// received bit ahead of all processing so an inverted link can be checked.
// rst_n is a synchronous reset asserted high despite its name.
module prbs31_checker
   import prbs31_pkg::*;
#(
   parameter int LOCK_CNT    = 64,
   parameter int WIN_LEN     = 128,
   parameter int LOSS_THRESH = 16,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_vld,
   input  logic             cnt_clr,
`ifdef PRBS31_CHK_INV_EN
   input  logic             inv_in,
`endif
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [4:0]       FILL_LAST = 5'(LFSR_W - 1);
   localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
   localparam logic [7:0]       WIN_LAST  = 8'(WIN_LEN - 1);
   localparam logic [7:0]       LOSS_LAST = 8'(LOSS_THRESH - 1);
   localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [4:0]          fill_cnt_q, fill_cnt_d;
   logic [7:0]          match_cnt_q, match_cnt_d;
   logic [7:0]          win_bits_q, win_bits_d;
   logic [7:0]          win_err_q, win_err_d;
   logic                err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0]    err_count_q, err_count_d;

   logic                data_bit;
   logic                pred;
   logic                shift_bit;
   logic                mismatch;
   logic [LFSR_W-1:0]   lfsr_next;

`ifdef PRBS31_CHK_INV_EN
   assign data_bit = bit_in ^ inv_in;
`else
   assign data_bit = bit_in;
`endif

   // Once locked the register free-runs on its own prediction so a line error
   // never enters the reference and is counted exactly once.
   assign shift_bit = (state_q == LOCKED) ? pred : data_bit;
   assign mismatch  = data_bit ^ pred;

   prbs31_step u_step (
      .lfsr_i      (lfsr_q),
      .bit_i       (shift_bit),
      .pred_o      (pred),
      .lfsr_next_o (lfsr_next)
   );

   // Next-state logic for the lock FSM, the LFSR and all counters.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      win_bits_d  = win_bits_q;
      win_err_d   = win_err_q;
      err_pulse_d = 1'b0;
      err_count_d = cnt_clr ? '0 : err_count_q;

      case (state_q)
         SEARCH: begin
            if (bit_vld) begin
               lfsr_d = lfsr_next;
               if (fill_cnt_q == FILL_LAST) begin
                  state_d     = VERIFY;
                  fill_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  fill_cnt_d = fill_cnt_q + 5'd1;
               end
            end
         end

         VERIFY: begin
            // An all-zero register predicts zeros forever; refuse to lock on it.
            if (lfsr_q == '0) begin
               state_d    = SEARCH;
               fill_cnt_d = '0;
            end else if (bit_vld) begin
               lfsr_d = lfsr_next;
               if (mismatch) begin
                  state_d    = SEARCH;
                  fill_cnt_d = '0;
               end else if (match_cnt_q == LOCK_LAST) begin
                  state_d    = LOCKED;
                  win_bits_d = '0;
                  win_err_d  = '0;
               end else begin
                  match_cnt_d = match_cnt_q + 8'd1;
               end
            end
         end

         LOCKED: begin
            if (bit_vld) begin
               lfsr_d = lfsr_next;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  if (err_count_d != '1) begin
                     err_count_d = err_count_d + ERR_ONE;
                  end
               end
               // The loss check takes priority so an error on the last bit of a
               // window still contributes to that window.
               if (mismatch && (win_err_q == LOSS_LAST)) begin
                  state_d    = SEARCH;
                  fill_cnt_d = '0;
               end else if (win_bits_q == WIN_LAST) begin
                  win_bits_d = '0;
                  win_err_d  = '0;
               end else begin
                  win_bits_d = win_bits_q + 8'd1;
                  win_err_d  = win_err_q + {7'd0, mismatch};
               end
            end
         end

         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= SEARCH;
         lfsr_q      <= '0;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_bits_q  <= '0;
         win_err_q   <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_bits_q  <= win_bits_d;
         win_err_q   <= win_err_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed testbench for prbs31_checker. Two instances share the stimulus:
// dut_a with the default 16-bit counter, dut_b with a 4-bit counter so that
// saturation is reachable. Expected values are hand-derived constants.
module tb_prbs31_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_in;
   logic        bit_vld;
   logic        cnt_clr;
   logic        locked_a, err_pulse_a;
   logic [15:0] err_count_a;
   logic        locked_b, err_pulse_b;
   logic [3:0]  err_count_b;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [30:0] gen_q;
   int          pulses;
   int          unlocked;
   int          vcount;
   int          iter;
   logic        ever_locked;

   always #5 clk = ~clk;

   prbs31_checker #(.ERR_W(16)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_vld   (bit_vld),
      .cnt_clr   (cnt_clr),
`ifdef PRBS31_CHK_INV_EN
      .inv_in    (1'b0),
`endif
      .locked    (locked_a),
      .err_pulse (err_pulse_a),
      .err_count (err_count_a)
   );

   prbs31_checker #(.ERR_W(4)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_vld   (bit_vld),
      .cnt_clr   (cnt_clr),
`ifdef PRBS31_CHK_INV_EN
      .inv_in    (1'b0),
`endif
      .locked    (locked_b),
      .err_pulse (err_pulse_b),
      .err_count (err_count_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Reference PRBS31 generator: emit tap XOR, shift it back in.
   task automatic gen_bit(output logic b);
      b     = gen_q[27] ^ gen_q[30];
      gen_q = {gen_q[29:0], b};
   endtask

   // Drive one cycle, then sample 1 time unit after the rising edge.
   task automatic tick(input logic b, input logic v, input logic c);
      bit_in  = b;
      bit_vld = v;
      cnt_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_clean();
      logic b;
      gen_bit(b);
      tick(b, 1'b1, 1'b0);
   endtask

   task automatic send_err(input logic c);
      logic b;
      gen_bit(b);
      tick(~b, 1'b1, c);
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      repeat (3) tick(1'($urandom), 1'b1, 1'b0);
      rst_n = 1'b0;
      gen_q = 31'd1;
   endtask

   initial begin
      rst_n   = 1'b1;
      bit_in  = 1'b0;
      bit_vld = 1'b0;
      cnt_clr = 1'b0;
      gen_q   = 31'd1;

      // Reset state
      do_reset();
      chk("reset_locked", 32'(locked_a), 0);
      chk("reset_pulse", 32'(err_pulse_a), 0);
      chk("reset_cnt_a", 32'(err_count_a), 0);
      chk("reset_cnt_b", 32'(err_count_b), 0);

      // Clean lock: 31 fill + 64 verify bits
      repeat (94) send_clean();
      chk("lock_after_94", 32'(locked_a), 0);
      send_clean();
      chk("lock_after_95", 32'(locked_a), 1);
      pulses   = 0;
      unlocked = 0;
      repeat (10000) begin
         send_clean();
         if (err_pulse_a) pulses++;
         if (!locked_a) unlocked++;
      end
      chk("clean_pulses", 32'(pulses), 0);
      chk("clean_cnt", 32'(err_count_a), 0);
      chk("clean_unlocked_cycles", 32'(unlocked), 0);

      // Single error
      send_err(1'b0);
      chk("single_pulse", 32'(err_pulse_a), 1);
      chk("single_cnt", 32'(err_count_a), 1);
      chk("single_locked", 32'(locked_a), 1);
      send_clean();
      chk("single_pulse_drop", 32'(err_pulse_a), 0);
      repeat (50) send_clean();
      chk("single_cnt_hold", 32'(err_count_a), 1);

      // Error followed by a gap; gap cycles are transparent
      send_err(1'b0);
      chk("gap_err_pulse", 32'(err_pulse_a), 1);
      tick(1'($urandom), 1'b0, 1'b0);
      chk("gap_pulse_low", 32'(err_pulse_a), 0);
      chk("gap_cnt", 32'(err_count_a), 2);
      repeat (20) tick(1'($urandom), 1'b0, 1'b0);
      send_clean();
      chk("gap_after_pulse", 32'(err_pulse_a), 0);
      chk("gap_after_locked", 32'(locked_a), 1);
      chk("gap_after_cnt", 32'(err_count_a), 2);

      // Reset in the middle of lock, together with an error bit
      rst_n = 1'b1;
      send_err(1'b0);
      chk("midrst_locked", 32'(locked_a), 0);
      chk("midrst_pulse", 32'(err_pulse_a), 0);
      chk("midrst_cnt", 32'(err_count_a), 0);
      rst_n = 1'b0;
      gen_q = 31'd1;

      // Loss of lock: 16 consecutive errors right after locking
      repeat (95) send_clean();
      chk("loss_prelock", 32'(locked_a), 1);
      repeat (15) send_err(1'b0);
      chk("loss_after_15", 32'(locked_a), 1);
      send_err(1'b0);
      chk("loss_after_16", 32'(locked_a), 0);
      chk("loss_pulse_16", 32'(err_pulse_a), 1);
      chk("loss_cnt_a", 32'(err_count_a), 16);
      chk("loss_cnt_b_sat", 32'(err_count_b), 15);
      repeat (94) send_clean();
      chk("relock_after_94", 32'(locked_a), 0);
      send_clean();
      chk("relock_after_95", 32'(locked_a), 1);
      chk("relock_cnt_kept", 32'(err_count_a), 16);

      // Clear, then 20 errors spaced 20 bits apart
      begin
         logic b;
         gen_bit(b);
         tick(b, 1'b1, 1'b1);
      end
      chk("clr_cnt_a", 32'(err_count_a), 0);
      chk("clr_cnt_b", 32'(err_count_b), 0);
      repeat (20) begin
         send_err(1'b0);
         repeat (19) send_clean();
      end
      chk("spaced_cnt_a", 32'(err_count_a), 20);
      chk("spaced_cnt_b_sat", 32'(err_count_b), 15);
      chk("spaced_locked", 32'(locked_a), 1);

      // Clear coinciding with an error: error counted after clear
      send_err(1'b1);
      chk("clr_err_cnt_a", 32'(err_count_a), 1);
      chk("clr_err_cnt_b", 32'(err_count_b), 1);
      chk("clr_err_pulse", 32'(err_pulse_a), 1);

      // 30% valid duty from reset
      do_reset();
      vcount = 0;
      iter   = 0;
      while (vcount < 95 && iter < 20000) begin
         iter++;
         if ($urandom_range(0, 99) < 30) begin
            send_clean();
            vcount++;
            if (vcount == 94) chk("duty_after_94", 32'(locked_a), 0);
         end else begin
            tick(1'($urandom), 1'b0, 1'b0);
         end
      end
      chk("duty_valid_bits", 32'(vcount), 95);
      chk("duty_locked", 32'(locked_a), 1);
      pulses = 0;
      repeat (600) begin
         if ($urandom_range(0, 99) < 30) send_clean();
         else tick(1'($urandom), 1'b0, 1'b0);
         if (err_pulse_a) pulses++;
      end
      chk("duty_pulses", 32'(pulses), 0);
      chk("duty_cnt", 32'(err_count_a), 0);
      chk("duty_still_locked", 32'(locked_a), 1);

      // Stuck-at-zero input must never lock
      do_reset();
      ever_locked = 1'b0;
      repeat (1000) begin
         tick(1'b0, 1'b1, 1'b0);
         if (locked_a) ever_locked = 1'b1;
      end
      chk("stuck_zero_never_locked", 32'(ever_locked), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side checker for the PRBS31 stream (x^31 + x^28 + 1) produced by the team's PRBS31 generator.
- Self-synchronises to an incoming serial bit stream and declares lock.
- Once locked, flags each bit error and counts errors in a saturating counter; declares loss of lock on excessive errors.
- Sits between the TT input pins and the status/count outputs of the top-level wrapper.

Parameters:
- LOCK_CNT, 64: consecutive matching valid bits in VERIFY required to enter LOCKED (range 1..255).
- WIN_LEN, 128: length of the loss-of-lock window, in valid bits (range 2..255).
- LOSS_THRESH, 16: errors within one window that force loss of lock (range 1..WIN_LEN).
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-high reset: 1 = reset, sampled on the clk rising edge.
- bit_in  in  1  received serial data bit.
- bit_vld  in  1  bit_in is valid this cycle; cycles with bit_vld=0 are ignored entirely.
- cnt_clr  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per detected bit error (LOCKED only).
- err_count  out  ERR_W  saturating error count.

Behaviour:
- Reset (rst_n=1): state=SEARCH, lfsr=0, all counters=0, locked=0, err_pulse=0, err_count=0. Reset wins over every other input, including mid-lock.
- Predicted bit: p = lfsr[27] ^ lfsr[30]. Shift rule: lfsr <= {lfsr[29:0], b}.
- SEARCH:
  - Each valid bit shifts b=bit_in into lfsr and increments fill_cnt.
  - After the 31st valid bit: go to VERIFY and clear match_cnt.
- VERIFY:
  - Each valid bit shifts b=bit_in (self-synchronising) and compares bit_in with p.
  - Match: match_cnt++. When match_cnt reaches LOCK_CNT: go to LOCKED and clear the window counters.
  - Mismatch: go to SEARCH and clear fill_cnt.
  - lfsr==0 at any VERIFY cycle: go to SEARCH. This blocks lock on an all-zero stream.
- LOCKED:
  - Each valid bit shifts b=p (free-running reference), so one line error is counted exactly once.
  - bit_in != p: err_pulse=1 on the next cycle, err_count++ on the same edge, win_err++.
  - win_bits counts valid bits. When it reaches WIN_LEN, both window counters reset.
  - win_err reaching LOSS_THRESH: go to SEARCH immediately. locked drops the next cycle; fill_cnt is cleared. The error that triggers this is still pulsed and counted.
- Output timing:
  - locked and err_pulse are registered, with 1-cycle latency from the deciding valid bit.
  - err_pulse is 0 in cycles with no valid bit.
- err_count:
  - Saturates at 2^ERR_W-1 and never wraps.
  - cnt_clr sets it to 0. If cnt_clr coincides with an error, the result is 1 (error counted after clear).
  - Not cleared by loss of lock.
- bit_vld gaps: state and lfsr hold. Gaps of any length are transparent.

Optional Feature:
- Macro: PRBS31_CHK_INV_EN.
- Defined:
  - Adds input port inv_in (1 bit). When inv_in=1, bit_in is inverted before all SEARCH, VERIFY and LOCKED processing. This allows checking an inverted link.
  - Under inversion an all-ones raw stream is rejected through the lfsr==0 rule.
- Undefined: the port is absent and bit_in is used directly.

Decomposition:
- Shared package prbs31_pkg:
  - PRBS31 tap constants TAP_A=30, TAP_B=27, LFSR_W=31.
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Also used by the generator.
- One natural sub-module, prbs31_step: combinational next-state and predicted-bit function, shared with the generator.
- Lock FSM and counters stay in prbs31_checker.

Test Plan:
- Reset: hold rst_n=1 three cycles with random bit_in -> locked=0, err_pulse=0, err_count=0.
- Clean lock: generator stream seeded 31'd1, bit_vld=1 continuously -> locked rises on the cycle after valid bit 31+64=95; err_count stays 0 over 10000 bits.
- Single error: when locked, flip one bit -> exactly one err_pulse, err_count=1, locked stays 1.
- Loss of lock: when locked, invert 16 bits within 128 -> locked=0 after the 16th error, err_count=16; clean stream afterward -> relock after a further 95 valid bits.
- Stuck zero: bit_in=0 for 1000 valid cycles -> locked never asserts.
- Gaps, saturation, clear:
  - Random bit_vld duty (30%) on a clean stream -> locks, 0 errors.
  - ERR_W=4 with 20 errors spaced out -> err_count=15.
  - cnt_clr in the same cycle as an error -> err_count=1.
